eth_phy_10g_tx_if: RTL and testbench
====================================

ETH_PHY_10G_TX_IF -- requirements
Module: eth_phy_10g_tx_if

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, encoded/SERDES data width; only 64 legal, else $error and $finish.
REQ-002 SHALL have parameter HDR_WIDTH, default 2, sync header width; only 2 legal, else $error and $finish.
REQ-003 SHALL have parameter BIT_REVERSE, default 0, 1 = reverse bit order of data and header at the SERDES output.
REQ-004 SHALL have parameter SCRAMBLER_DISABLE, default 0, 1 = data passes unscrambled.
REQ-005 SHALL have parameter SERDES_PIPELINE, default 0, number of extra output register stages (0..4).
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port encoded_tx_data  input  64  64b/66b block payload, bit 0 transmitted first.
REQ-009 SHALL have port encoded_tx_hdr  input  2  sync header, bit 0 transmitted first.
REQ-010 SHALL have port serdes_tx_data  output  64  scrambled (or PRBS) payload to SERDES.
REQ-011 SHALL have port serdes_tx_hdr  output  2  header to SERDES.
REQ-012 SHALL have port tx_bad_hdr  output  1  one-cycle pulse: header of block now at output was 2'b00 or 2'b11.
REQ-013 SHALL have port tx_bad_hdr_count  output  7  saturating count of bad headers.
REQ-014 SHALL have port tx_prbs31_enable  input  1  selects PRBS31 test pattern (effective only when REQ-031 macro defined).

Function
REQ-015 SHALL accept one block every clk cycle; no handshake, no stall.
REQ-016 SHALL present each block at the outputs exactly 1 + SERDES_PIPELINE cycles after it is sampled.
REQ-017 SHALL scramble with self-synchronous polynomial x^58+x^39+1: per bit i (0..63 in order) out_i = d_i ^ s[38] ^ s[57], then s shifts left with out_i into s[0].
REQ-018 SHALL process all 64 bits of one block in one cycle (unrolled), storing the resulting 58-bit state.
REQ-019 SHALL never scramble the header; header passes unchanged.
REQ-020 SHALL, with SCRAMBLER_DISABLE=1, pass data unchanged and hold scrambler state constant.
REQ-021 SHALL flag tx_bad_hdr for headers 2'b00/2'b11, pipeline-aligned with that block's output; block still transmitted unchanged.
REQ-022 SHALL increment tx_bad_hdr_count by 1 per bad header, saturating at 127 (no wrap).
REQ-023 SHALL, with BIT_REVERSE=1, map data bit i to output bit 63-i and header bit i to 1-i, after scrambling/PRBS.
REQ-024 SHALL advance the scrambler only on cycles where PRBS mode is inactive.
REQ-025 SHALL suppress tx_bad_hdr and counting while PRBS mode is active.
REQ-026 SHALL apply a change of tx_prbs31_enable from the next sampled block; no partial block mixing.

Reset
REQ-027 SHALL, while rst is high, drive serdes_tx_data 64'h0, serdes_tx_hdr 2'b00, tx_bad_hdr 0, tx_bad_hdr_count 0 on all pipeline stages.
REQ-028 SHALL load scrambler state 58'h3FF_FFFF_FFFF_FFFF and PRBS31 state 31'h7FFF_FFFF on reset.
REQ-029 SHALL discard blocks in flight when rst asserts mid-stream; first valid output is the block sampled the cycle after rst deasserts, at REQ-016 latency.
REQ-030 SHALL have no reset-dependent behaviour beyond REQ-027..REQ-029.

Configuration
REQ-031 SHALL compile the PRBS31 generator only when macro ETH_PHY_10G_TX_PRBS31_EN is defined.
REQ-032 SHALL, with macro defined and tx_prbs31_enable=1, emit 66 PRBS31 bits per cycle (x^31+x^28+1: b = p[30]^p[27], p shifts left with b into p[0]), order hdr[0], hdr[1], data[0..63], bypassing scrambler.
REQ-033 SHALL, without the macro, contain no PRBS logic and ignore tx_prbs31_enable (normal scrambled path always).

Verification
REQ-034 SHALL cover: reset, SERDES_PIPELINE=0, all-zero data, hdr 2'b01 -> first output data[38:0]=0, data[39]=1, hdr 2'b01, one cycle after input.
REQ-035 SHALL cover: SCRAMBLER_DISABLE=1, data 64'h0123_4567_89AB_CDEF hdr 2'b10 -> identical output; with BIT_REVERSE=1 -> data 64'hF7B3_D591_E6A2_C480, hdr 2'b01.
REQ-036 SHALL cover: 130 consecutive hdr 2'b11 -> tx_bad_hdr high 130 cycles, count stops at 127; rst -> count 0.
REQ-037 SHALL cover: macro defined, reset, tx_prbs31_enable=1 -> first output hdr=2'b00, data[25:0]=0, data[28:26]=3'b111.
REQ-038 SHALL cover: SERDES_PIPELINE=3, rst asserted with 4 blocks in flight -> outputs at reset values next cycle; post-reset block appears exactly 4 cycles after sampling.
REQ-039 SHALL cover: macro undefined, tx_prbs31_enable=1 -> output identical to REQ-034 result.

Source files
------------

// File: rtl/eth_phy_10g_tx_if.sv
// rtl/eth_phy_10g_tx_if.sv - 10GBASE-R TX: x^58+x^39+1 scrambler, bad-header monitor, SERDES output pipeline
// Optional PRBS31 test-pattern generator is built only when ETH_PHY_10G_TX_PRBS31_EN is defined.
module eth_phy_10g_tx_if #(
  parameter int DATA_WIDTH        = 64,
  parameter int HDR_WIDTH         = 2,
  parameter int BIT_REVERSE       = 0,
  parameter int SCRAMBLER_DISABLE = 0,
  parameter int SERDES_PIPELINE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] encoded_tx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
  output logic [DATA_WIDTH-1:0] serdes_tx_data,
  output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
  output logic                  tx_bad_hdr,
  output logic [6:0]            tx_bad_hdr_count,
  input  logic                  tx_prbs31_enable
);
  localparam int LAST = SERDES_PIPELINE;

  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("eth_phy_10g_tx_if: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("eth_phy_10g_tx_if: HDR_WIDTH must be 2");
  end
  if (SERDES_PIPELINE < 0 || SERDES_PIPELINE > 4) begin : g_bad_pipeline
    $error("eth_phy_10g_tx_if: SERDES_PIPELINE must be 0..4");
  end

  logic [57:0]           scr_q, scr_d, scr_tmp;
  logic [DATA_WIDTH-1:0] scr_data;
  logic [DATA_WIDTH-1:0] blk_data, out_data;
  logic [HDR_WIDTH-1:0]  blk_hdr, out_hdr;
  logic                  blk_bad, hdr_bad;
  logic [DATA_WIDTH-1:0] data_q [0:LAST];
  logic [DATA_WIDTH-1:0] data_d [0:LAST];
  logic [HDR_WIDTH-1:0]  hdr_q [0:LAST];
  logic [HDR_WIDTH-1:0]  hdr_d [0:LAST];
  logic [LAST:0]         bad_q, bad_d;
  logic [6:0]            cnt_q, cnt_d;

  // Unrolled bit-serial scrambler: bit 0 goes through the LFSR first.
  always_comb begin : scrambler
    scr_tmp  = scr_q;
    scr_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      scr_data[i] = encoded_tx_data[i] ^ scr_tmp[38] ^ scr_tmp[57];
      scr_tmp     = {scr_tmp[56:0], scr_data[i]};
    end
  end

  assign hdr_bad = (encoded_tx_hdr[0] == encoded_tx_hdr[1]);

`ifdef ETH_PHY_10G_TX_PRBS31_EN
  logic [30:0]                     prbs_q, prbs_d, prbs_tmp;
  logic [DATA_WIDTH+HDR_WIDTH-1:0] prbs_bits;

  always_comb begin : prbs31
    prbs_tmp  = prbs_q;
    prbs_bits = '0;
    for (int k = 0; k < DATA_WIDTH + HDR_WIDTH; k++) begin
      prbs_bits[k] = prbs_tmp[30] ^ prbs_tmp[27];
      prbs_tmp     = {prbs_tmp[29:0], prbs_bits[k]};
    end
    prbs_d = tx_prbs31_enable ? prbs_tmp : prbs_q;
  end

  always_ff @(posedge clk) begin
    if (rst) prbs_q <= '1;
    else     prbs_q <= prbs_d;
  end

  // The whole block is either PRBS or payload, chosen by the enable sampled with it.
  always_comb begin : block_select
    if (tx_prbs31_enable) begin
      blk_data = prbs_bits[DATA_WIDTH+HDR_WIDTH-1:HDR_WIDTH];
      blk_hdr  = prbs_bits[HDR_WIDTH-1:0];
      blk_bad  = 1'b0;
      scr_d    = scr_q;
    end else begin
      blk_data = (SCRAMBLER_DISABLE != 0) ? encoded_tx_data : scr_data;
      blk_hdr  = encoded_tx_hdr;
      blk_bad  = hdr_bad;
      scr_d    = (SCRAMBLER_DISABLE != 0) ? scr_q : scr_tmp;
    end
  end
`else
  logic unused_prbs31_enable;
  assign unused_prbs31_enable = tx_prbs31_enable;

  always_comb begin : block_select
    blk_data = (SCRAMBLER_DISABLE != 0) ? encoded_tx_data : scr_data;
    blk_hdr  = encoded_tx_hdr;
    blk_bad  = hdr_bad;
    scr_d    = (SCRAMBLER_DISABLE != 0) ? scr_q : scr_tmp;
  end
`endif

  always_comb begin : bit_order
    out_data = blk_data;
    out_hdr  = blk_hdr;
    if (BIT_REVERSE != 0) begin
      for (int i = 0; i < DATA_WIDTH; i++) out_data[i] = blk_data[DATA_WIDTH-1-i];
      for (int i = 0; i < HDR_WIDTH; i++)  out_hdr[i]  = blk_hdr[HDR_WIDTH-1-i];
    end
  end

  // Counter follows the flag at the output so it stays aligned with what the SERDES sees.
  always_comb begin : pipe_next
    data_d[0] = out_data;
    hdr_d[0]  = out_hdr;
    bad_d[0]  = blk_bad;
    for (int k = 1; k <= LAST; k++) begin
      data_d[k] = data_q[k-1];
      hdr_d[k]  = hdr_q[k-1];
      bad_d[k]  = bad_q[k-1];
    end
    cnt_d = (bad_q[LAST] && (cnt_q != 7'd127)) ? cnt_q + 7'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scr_q <= '1;
      cnt_q <= '0;
      bad_q <= '0;
      for (int k = 0; k <= LAST; k++) begin
        data_q[k] <= '0;
        hdr_q[k]  <= '0;
      end
    end else begin
      scr_q <= scr_d;
      cnt_q <= cnt_d;
      bad_q <= bad_d;
      for (int k = 0; k <= LAST; k++) begin
        data_q[k] <= data_d[k];
        hdr_q[k]  <= hdr_d[k];
      end
    end
  end

  assign serdes_tx_data   = data_q[LAST];
  assign serdes_tx_hdr    = hdr_q[LAST];
  assign tx_bad_hdr       = bad_q[LAST];
  assign tx_bad_hdr_count = cnt_q;
endmodule

// File: tb/tb_eth_phy_10g_tx_if.sv
// tb/tb_eth_phy_10g_tx_if.sv - randomized self-checking bench for eth_phy_10g_tx_if
// Four configurations share one stimulus stream; a bit-stream reference model predicts each output.
module tb_eth_phy_10g_tx_if;
`ifdef ETH_PHY_10G_TX_PRBS31_EN
  localparam bit PRBS_BUILT = 1'b1;
`else
  localparam bit PRBS_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] enc_data;
  logic [1:0]  enc_hdr;
  logic        prbs_en;
  logic [63:0] d0, d1, d2, d3;
  logic [1:0]  h0, h1, h2, h3;
  logic        b0, b1, b2, b3;
  logic [6:0]  c0, c1, c2, c3;

  always #5 clk = ~clk;

  eth_phy_10g_tx_if u_base (
    .clk(clk), .rst(rst), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
    .serdes_tx_data(d0), .serdes_tx_hdr(h0), .tx_bad_hdr(b0), .tx_bad_hdr_count(c0),
    .tx_prbs31_enable(prbs_en));
  eth_phy_10g_tx_if #(.SCRAMBLER_DISABLE(1)) u_raw (
    .clk(clk), .rst(rst), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
    .serdes_tx_data(d1), .serdes_tx_hdr(h1), .tx_bad_hdr(b1), .tx_bad_hdr_count(c1),
    .tx_prbs31_enable(prbs_en));
  eth_phy_10g_tx_if #(.SCRAMBLER_DISABLE(1), .BIT_REVERSE(1)) u_rev (
    .clk(clk), .rst(rst), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
    .serdes_tx_data(d2), .serdes_tx_hdr(h2), .tx_bad_hdr(b2), .tx_bad_hdr_count(c2),
    .tx_prbs31_enable(prbs_en));
  eth_phy_10g_tx_if #(.SERDES_PIPELINE(3)) u_pipe (
    .clk(clk), .rst(rst), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
    .serdes_tx_data(d3), .serdes_tx_hdr(h3), .tx_bad_hdr(b3), .tx_bad_hdr_count(c3),
    .tx_prbs31_enable(prbs_en));

  typedef struct packed {
    logic [63:0] scr;
    logic [63:0] raw;
    logic [1:0]  hdr;
    logic        bad;
  } exp_t;

  exp_t hist [0:3];
  int   cnt_m, cnt_p;
  bit   scr_bits[$];
  bit   prbs_bits[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[63-i];
    return r;
  endfunction

  task automatic model_reset();
    scr_bits.delete();
    repeat (58) scr_bits.push_back(1'b1);
    prbs_bits.delete();
    repeat (31) prbs_bits.push_back(1'b1);
    for (int k = 0; k < 4; k++) hist[k] = '0;
    cnt_m = 0;
    cnt_p = 0;
  endtask

  // Scrambled bit = data ^ line bit 39 back ^ line bit 58 back; PRBS bit = bit 31 back ^ bit 28 back.
  task automatic model_block(input logic [63:0] d, input logic [1:0] h, input logic p, output exp_t e);
    bit b;
    e = '0;
    if (PRBS_BUILT && p) begin
      for (int k = 0; k < 66; k++) begin
        b = prbs_bits[prbs_bits.size()-31] ^ prbs_bits[prbs_bits.size()-28];
        prbs_bits.push_back(b);
        void'(prbs_bits.pop_front());
        if (k < 2) e.hdr[k] = b;
        else begin
          e.scr[k-2] = b;
          e.raw[k-2] = b;
        end
      end
    end else begin
      for (int i = 0; i < 64; i++) begin
        b = d[i] ^ scr_bits[scr_bits.size()-39] ^ scr_bits[scr_bits.size()-58];
        scr_bits.push_back(b);
        void'(scr_bits.pop_front());
        e.scr[i] = b;
      end
      e.raw = d;
      e.hdr = h;
      e.bad = (h == 2'b00) || (h == 2'b11);
    end
  endtask

  task automatic cycle(input logic [63:0] d, input logic [1:0] h, input logic r, input logic p);
    exp_t e;
    enc_data = d;
    enc_hdr  = h;
    rst      = r;
    prbs_en  = p;
    @(posedge clk);
    if (r) model_reset();
    else begin
      if (hist[0].bad && cnt_m < 127) cnt_m++;
      if (hist[3].bad && cnt_p < 127) cnt_p++;
      model_block(d, h, p, e);
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = e;
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    for (int n = 0; n < 3; n++) begin
      cycle(rnd64(), 2'($urandom), 1'b1, 1'b0);
      checks++;
      if ({d0, h0, b0, c0, d1, h1, b1, c1, d2, h2, b2, c2, d3, h3, b3, c3} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got base %h/%b/%b/%0d pipe %h/%b/%b/%0d, expected all zero",
                 d0, h0, b0, c0, d3, h3, b3, c3);
      end
    end
  endtask

  task automatic test_scramble_zero();
    cycle(rnd64(), 2'b01, 1'b1, 1'b0);
    cycle(64'h0, 2'b01, 1'b0, 1'b0);
    checks++;
    if (d0[39:0] !== 40'h80_0000_0000 || h0 !== 2'b01) begin
      errors++;
      $display("FAIL scramble_zero_first: got data[39:0] %h hdr %b, expected 8000000000 hdr 01", d0[39:0], h0);
    end
    checks++;
    if (d0 !== hist[0].scr) begin
      errors++;
      $display("FAIL scramble_zero_model: got %h, expected %h", d0, hist[0].scr);
    end
  endtask

  task automatic test_passthrough();
    cycle(rnd64(), 2'b01, 1'b1, 1'b0);
    cycle(64'h0123_4567_89AB_CDEF, 2'b10, 1'b0, 1'b0);
    checks++;
    if (d1 !== 64'h0123_4567_89AB_CDEF || h1 !== 2'b10) begin
      errors++;
      $display("FAIL passthrough: got %h/%b, expected 0123456789abcdef/10", d1, h1);
    end
    checks++;
    if (d2 !== 64'hF7B3_D591_E6A2_C480 || h2 !== 2'b01) begin
      errors++;
      $display("FAIL bit_reverse: got %h/%b, expected f7b3d591e6a2c480/01", d2, h2);
    end
  endtask

  task automatic test_bad_hdr_sat();
    int pulses = 0;
    cycle(rnd64(), 2'b01, 1'b1, 1'b0);
    for (int n = 0; n < 130; n++) begin
      cycle(rnd64(), 2'b11, 1'b0, 1'b0);
      if (b0 === 1'b1) pulses++;
      checks++;
      if (c0 !== 7'(cnt_m)) begin
        errors++;
        $display("FAIL bad_hdr_count_step %0d: got %0d, expected %0d", n, c0, cnt_m);
      end
    end
    checks++;
    if (pulses != 130) begin
      errors++;
      $display("FAIL bad_hdr_pulses: got %0d cycles high, expected 130", pulses);
    end
    cycle(rnd64(), 2'b01, 1'b0, 1'b0);
    checks++;
    if (b0 !== 1'b0) begin
      errors++;
      $display("FAIL bad_hdr_clear: got %b, expected 0", b0);
    end
    cycle(rnd64(), 2'b10, 1'b0, 1'b0);
    checks++;
    if (c0 !== 7'd127 || c3 !== 7'(cnt_p)) begin
      errors++;
      $display("FAIL bad_hdr_saturate: got %0d (pipe %0d), expected 127 (pipe %0d)", c0, c3, cnt_p);
    end
    cycle(rnd64(), 2'b11, 1'b1, 1'b0);
    checks++;
    if (c0 !== 7'd0) begin
      errors++;
      $display("FAIL bad_hdr_count_reset: got %0d, expected 0", c0);
    end
  endtask

  task automatic test_pipeline_reset();
    exp_t xe;
    cycle(rnd64(), 2'b01, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) cycle(rnd64(), 2'b11, 1'b0, 1'b0);
    cycle(rnd64(), 2'b11, 1'b1, 1'b0);
    checks++;
    if ({d3, h3, b3} !== '0) begin
      errors++;
      $display("FAIL pipe_flush: got %h/%b/%b, expected zero", d3, h3, b3);
    end
    cycle(rnd64(), 2'b11, 1'b0, 1'b0);
    xe = hist[0];
    for (int n = 1; n <= 4; n++) begin
      if (n > 1) cycle(rnd64(), 2'b01, 1'b0, 1'b0);
      checks++;
      if (n < 4 && {d3, h3, b3} !== '0) begin
        errors++;
        $display("FAIL pipe_early cycle %0d: got %h/%b/%b, expected zero", n, d3, h3, b3);
      end else if (n == 4 && {d3, h3, b3} !== {xe.scr, xe.hdr, 1'b1}) begin
        errors++;
        $display("FAIL pipe_latency: got %h/%b/%b, expected %h/%b/1", d3, h3, b3, xe.scr, xe.hdr);
      end
    end
  endtask

  task automatic test_random();
    logic p = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) p = ~p;
      cycle(rnd64(), 2'($urandom), ($urandom_range(0, 39) == 0), p);
      checks++;
      if ({d0, h0, b0, c0} !== {hist[0].scr, hist[0].hdr, hist[0].bad, 7'(cnt_m)}) begin
        errors++;
        $display("FAIL random_base %0d: got %h/%b/%b/%0d, expected %h/%b/%b/%0d",
                 n, d0, h0, b0, c0, hist[0].scr, hist[0].hdr, hist[0].bad, cnt_m);
      end
      checks++;
      if ({d1, h1, b1, c1} !== {hist[0].raw, hist[0].hdr, hist[0].bad, 7'(cnt_m)}) begin
        errors++;
        $display("FAIL random_raw %0d: got %h/%b/%b/%0d, expected %h/%b/%b/%0d",
                 n, d1, h1, b1, c1, hist[0].raw, hist[0].hdr, hist[0].bad, cnt_m);
      end
      checks++;
      if ({d2, h2, b2, c2} !== {rev64(hist[0].raw), hist[0].hdr[0], hist[0].hdr[1], hist[0].bad, 7'(cnt_m)}) begin
        errors++;
        $display("FAIL random_rev %0d: got %h/%b/%b/%0d, expected %h/%b%b/%b/%0d",
                 n, d2, h2, b2, c2, rev64(hist[0].raw), hist[0].hdr[0], hist[0].hdr[1], hist[0].bad, cnt_m);
      end
      checks++;
      if ({d3, h3, b3, c3} !== {hist[3].scr, hist[3].hdr, hist[3].bad, 7'(cnt_p)}) begin
        errors++;
        $display("FAIL random_pipe %0d: got %h/%b/%b/%0d, expected %h/%b/%b/%0d",
                 n, d3, h3, b3, c3, hist[3].scr, hist[3].hdr, hist[3].bad, cnt_p);
      end
    end
  endtask

`ifdef ETH_PHY_10G_TX_PRBS31_EN
  task automatic test_prbs();
    cycle(rnd64(), 2'b01, 1'b1, 1'b1);
    cycle(rnd64(), 2'b11, 1'b0, 1'b1);
    checks++;
    if (h0 !== 2'b00 || d0[28:0] !== 29'h1C00_0000 || b0 !== 1'b0) begin
      errors++;
      $display("FAIL prbs_first: got hdr %b data[28:0] %h bad %b, expected 00/1c000000/0", h0, d0[28:0], b0);
    end
    checks++;
    if (d0 !== hist[0].scr) begin
      errors++;
      $display("FAIL prbs_model: got %h, expected %h", d0, hist[0].scr);
    end
  endtask
`else
  task automatic test_prbs_ignored();
    cycle(rnd64(), 2'b01, 1'b1, 1'b1);
    cycle(64'h0, 2'b01, 1'b0, 1'b1);
    checks++;
    if (d0[39:0] !== 40'h80_0000_0000 || h0 !== 2'b01 || d0 !== hist[0].scr) begin
      errors++;
      $display("FAIL prbs_ignored: got %h/%b, expected %h/01", d0, h0, hist[0].scr);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    enc_data = '0;
    enc_hdr  = 2'b01;
    prbs_en  = 1'b0;
    model_reset();
    test_reset();
    test_scramble_zero();
    test_passthrough();
    test_bad_hdr_sat();
    test_pipeline_reset();
`ifdef ETH_PHY_10G_TX_PRBS31_EN
    test_prbs();
`else
    test_prbs_ignored();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
